// File: rtl/pwm_sweep_gen.sv
// N_CH phase-staggered PWM outputs sharing one duty value, swept as a triangle or sawtooth,
// or taken from duty_in_i. Define PWM_COMPL_EN to add complementary outputs with dead-time.
module pwm_sweep_gen #(
  parameter int CNT_W    = 8,
  parameter int HOLD     = 100000000,
  parameter int HOLD_W   = 32,
  parameter int DUTY_INC = 64,
  parameter int N_CH     = 2,
  parameter int PH_OFS   = 128,
  parameter int DEAD     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [1:0]      mode_i,
  input  logic [CNT_W:0]  duty_in_i,
  output logic [N_CH-1:0] pwm_out_o,
`ifdef PWM_COMPL_EN
  output logic [N_CH-1:0] pwm_out_n_o,
`endif
  output logic [CNT_W:0]  duty_cur_o,
  output logic            step_pulse_o,
  output logic            dir_o
);
  localparam int               FULL     = 1 << CNT_W;
  localparam logic [CNT_W:0]   FULL_V   = (CNT_W+1)'(FULL);
  localparam logic [CNT_W-1:0] PCNT_MAX = CNT_W'(FULL - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD - 1);
  localparam logic [CNT_W+1:0] INC_V    = (CNT_W+2)'(DUTY_INC);
  localparam logic [1:0] M_TRI = 2'd0, M_SAW = 2'd1, M_FIX = 2'd2, M_OFF = 2'd3;

  if (HOLD < 1) begin : g_chk_hold
    $error("HOLD must be >= 1");
  end
  if (longint'(HOLD) >= (longint'(1) << HOLD_W)) begin : g_chk_hold_w
    $error("HOLD_W too narrow for HOLD");
  end
  if (DUTY_INC < 1 || DUTY_INC > FULL) begin : g_chk_inc
    $error("DUTY_INC must be 1..2^CNT_W");
  end
  if (N_CH < 1 || DEAD < 0) begin : g_chk_misc
    $error("N_CH must be >= 1 and DEAD >= 0");
  end

  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W:0]    pend_q, pend_d, duty_q, duty_d;
  logic              dir_q, dir_d, step_q, step_d;
  logic [1:0]        mode_q;
  logic [N_CH-1:0]   raw_q, raw_d;

  logic                    sweep, enter, wrap, hold_end;
  logic [CNT_W+1:0]        up_sum;
  logic signed [CNT_W+1:0] dn_diff;
  logic [CNT_W:0]          up_val, dn_val;
  logic                    up_sat, dn_zero;

  assign sweep    = (mode_i == M_TRI) || (mode_i == M_SAW);
  assign enter    = sweep && (mode_i != mode_q);
  assign wrap     = en_i && (pcnt_q == PCNT_MAX);
  assign hold_end = (hold_q == HOLD_MAX);

  // Saturating step candidates; the down path uses a signed intermediate so underflow is visible.
  always_comb begin
    up_sum  = {1'b0, pend_q} + INC_V;
    up_sat  = (up_sum >= {1'b0, FULL_V});
    up_val  = up_sat ? FULL_V : up_sum[CNT_W:0];
    dn_diff = $signed({1'b0, pend_q}) - $signed(INC_V);
    dn_zero = dn_diff[CNT_W+1] || (dn_diff == '0);
    dn_val  = dn_zero ? '0 : dn_diff[CNT_W:0];
  end

  always_comb begin
    pcnt_d = en_i ? pcnt_q + 1'b1 : '0;
    hold_d = hold_q;
    pend_d = pend_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    case (mode_i)
      M_FIX: begin
        hold_d = '0;
        pend_d = (duty_in_i > FULL_V) ? FULL_V : duty_in_i;
      end
      M_OFF: begin
        hold_d = '0;
        pend_d = '0;
      end
      default: begin
        if (enter) begin
          hold_d = '0;
          pend_d = duty_q;
          dir_d  = 1'b0;
        end else if (!en_i) begin
          hold_d = '0;
        end else if (hold_end) begin
          hold_d = '0;
          step_d = 1'b1;
          if (mode_i == M_SAW) begin
            pend_d = (pend_q == FULL_V) ? '0 : up_val;
            dir_d  = 1'b0;
          end else if (!dir_q) begin
            pend_d = up_val;
            dir_d  = up_sat;
          end else begin
            pend_d = dn_val;
            dir_d  = !dn_zero;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
    // Loading the freshly computed pending value lets a step coinciding with wrap take effect now.
    duty_d = wrap ? pend_d : duty_q;
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cmp
    localparam logic [CNT_W-1:0] OFS = CNT_W'((gi * PH_OFS) % FULL);
    logic [CNT_W-1:0] phase;
    assign phase     = pcnt_q + OFS;
    assign raw_d[gi] = en_i && ({1'b0, phase} < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      hold_q <= '0;
      pend_q <= '0;
      duty_q <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      mode_q <= M_TRI;
      raw_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      duty_q <= duty_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      mode_q <= mode_i;
      raw_q  <= raw_d;
    end
  end

  assign duty_cur_o   = duty_q;
  assign step_pulse_o = step_q;
  assign dir_o        = dir_q;

`ifdef PWM_COMPL_EN
  localparam int DT_W = $clog2(DEAD + 1) + 1;
  localparam logic [DT_W-1:0] DEAD_V = DT_W'(DEAD);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_dt
    logic [DT_W-1:0] dt_q, dt_d;
    logic            p_q, p_d, n_q, n_d;

    // dt counts clocks the raw compare has been stable; either side drives only once it reaches DEAD.
    always_comb begin
      if (!en_i || (raw_d[gi] != raw_q[gi])) begin
        dt_d = '0;
      end else if (dt_q != DEAD_V) begin
        dt_d = dt_q + 1'b1;
      end else begin
        dt_d = dt_q;
      end
      p_d = raw_d[gi] && (dt_d == DEAD_V);
      n_d = en_i && !raw_d[gi] && (dt_d == DEAD_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dt_q <= '0;
        p_q  <= 1'b0;
        n_q  <= 1'b0;
      end else begin
        dt_q <= dt_d;
        p_q  <= p_d;
        n_q  <= n_d;
      end
    end

    assign pwm_out_o[gi]   = p_q;
    assign pwm_out_n_o[gi] = n_q;
  end
`else
  assign pwm_out_o = raw_q;
`endif
endmodule

// File: tb/tb_pwm_sweep_gen.sv
// Scoreboard bench for pwm_sweep_gen: two instances (step 4 and step 5) share all stimulus.
module tb_pwm_sweep_gen;
  localparam int CNT_W = 4, FULL = 16, HOLD = 32, N_CH = 2, PH_OFS = 8, DEAD = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W:0]   duty_in = '0;
  logic [N_CH-1:0]  pwm_a, pwm_b;
  logic [CNT_W:0]   duty_a, duty_b;
  logic             step_a, step_b, dir_a, dir_b;
`ifdef PWM_COMPL_EN
  logic [N_CH-1:0]  pwmn_a, pwmn_b;
`endif

  always #5 clk = ~clk;

  pwm_sweep_gen #(.CNT_W(CNT_W), .HOLD(HOLD), .HOLD_W(8), .DUTY_INC(4), .N_CH(N_CH),
                  .PH_OFS(PH_OFS), .DEAD(DEAD)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .duty_in_i(duty_in),
    .pwm_out_o(pwm_a),
`ifdef PWM_COMPL_EN
    .pwm_out_n_o(pwmn_a),
`endif
    .duty_cur_o(duty_a), .step_pulse_o(step_a), .dir_o(dir_a));

  pwm_sweep_gen #(.CNT_W(CNT_W), .HOLD(HOLD), .HOLD_W(8), .DUTY_INC(5), .N_CH(N_CH),
                  .PH_OFS(PH_OFS), .DEAD(DEAD)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .duty_in_i(duty_in),
    .pwm_out_o(pwm_b),
`ifdef PWM_COMPL_EN
    .pwm_out_n_o(pwmn_b),
`endif
    .duty_cur_o(duty_b), .step_pulse_o(step_b), .dir_o(dir_b));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {int duty; int dir;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic push2(input int da, input int db, input int dr);
    exp_t e;
    e.duty = da; e.dir = dr; q_a.push_back(e);
    e.duty = db; q_b.push_back(e);
  endtask

  // Bench-side view of the period counter: edges seen since enable, restarting on en=0.
  int   edge_cnt = 0;
  logic en_edge = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 0;
      en_edge  <= 1'b0;
    end else begin
      en_edge  <= en;
      edge_cnt <= en ? edge_cnt + 1 : 0;
    end
  end

  function automatic int exp_bit(input int k, input int duty);
    if (!en_edge) return 0;
    return (((edge_cnt - 1 + k * PH_OFS) % FULL) < duty) ? 1 : 0;
  endfunction

  task automatic sb_check(input int d, input int duty, input int dir);
    exp_t e;
    if (d == 0) begin
      if (q_a.size() == 0) begin check_eq("sb_unexp_a", duty, -1); return; end
      e = q_a.pop_front();
    end else begin
      if (q_b.size() == 0) begin check_eq("sb_unexp_b", duty, -1); return; end
      e = q_b.pop_front();
    end
    $display("duty change dut%0d: duty=%0d dir=%0d (exp %0d/%0d) edge=%0d", d, duty, dir, e.duty, e.dir, edge_cnt);
    check_eq(d == 0 ? "duty_a" : "duty_b", duty, e.duty);
    check_eq(d == 0 ? "dir_a" : "dir_b", dir, e.dir);
    check_eq("wrap_align", (en_edge && (edge_cnt % FULL == 0)) ? 1 : 0, 1);
  endtask

  int prev_a = 0, prev_b = 0, steps = 0;
  int win_duty = -1, last_win = -1, win_hi = 0, win_n = 0, win_p = 0, win_nn = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = 0;
      prev_b = 0;
      win_n  = 0;
    end else begin
      steps += int'(step_a);
`ifndef PWM_COMPL_EN
      for (int k = 0; k < N_CH; k++) begin
        check_eq("pwm_a_bit", int'(pwm_a[k]), exp_bit(k, prev_a));
        check_eq("pwm_b_bit", int'(pwm_b[k]), exp_bit(k, prev_b));
      end
`else
      for (int k = 0; k < N_CH; k++) begin
        check_eq("compl_overlap", int'(pwm_a[k] & pwmn_a[k]), 0);
      end
`endif
      if (edge_cnt % FULL == 1) begin
        win_duty = prev_a; win_hi = 0; win_n = 0; win_p = 0; win_nn = 0;
      end
      if (en_edge) begin
        win_n++;
        win_hi += int'(pwm_a[0]);
`ifdef PWM_COMPL_EN
        win_p  += int'(pwm_a[0]);
        win_nn += int'(pwmn_a[0]);
`endif
      end
      if (en_edge && (edge_cnt % FULL == 0) && win_n == FULL) begin
`ifndef PWM_COMPL_EN
        check_eq("win_high", win_hi, win_duty);
`else
        if (win_duty == last_win && win_duty == 8) begin
          check_eq("compl_p_hi", win_p, 6);
          check_eq("compl_n_hi", win_nn, 6);
        end
        if (win_duty == last_win && win_duty == 1) check_eq("compl_short", win_p, 0);
`endif
        last_win = win_duty;
      end
      if (int'(duty_a) != prev_a) sb_check(0, int'(duty_a), int'(dir_a));
      if (int'(duty_b) != prev_b) sb_check(1, int'(duty_b), int'(dir_b));
      prev_a = int'(duty_a);
      prev_b = int'(duty_b);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int s0;
  initial begin
    #1;
    check_eq("rst_pwm", int'(pwm_a), 0);
    check_eq("rst_duty", int'(duty_a), 0);
    check_eq("rst_step", int'(step_a), 0);
    check_eq("rst_dir", int'(dir_a), 0);
    run(3);

    // Triangle sweep
    push2(4, 5, 0);  push2(8, 10, 0);  push2(12, 15, 0); push2(16, 16, 1);
    push2(12, 11, 1); push2(8, 6, 1);  push2(4, 1, 1);   push2(0, 0, 0);
    push2(4, 5, 0);
    s0 = steps;
    rst_n = 1'b1;
    run(300);
    check_eq("tri_steps", steps - s0, 9);

    // Sawtooth, continuing from the current duty
    push2(8, 10, 0); push2(12, 15, 0); push2(16, 16, 0); push2(0, 0, 0); push2(4, 5, 0);
    s0 = steps;
    mode = 2'd1;
    run(180);
    check_eq("saw_steps", steps - s0, 5);

    // Fixed duty, including clamp and a mid-period change
    s0 = steps;
    mode = 2'd2; duty_in = 5'd20; push2(16, 16, 0);
    run(40);
    duty_in = 5'd0; push2(0, 0, 0);
    run(40);
    for (int i = 0; i < 2 * FULL && (edge_cnt % FULL != 8); i++) run(1);
    check_eq("mid_align", edge_cnt % FULL, 8);
    duty_in = 5'd3; push2(3, 3, 0);
    run(40);
    check_eq("fix_steps", steps - s0, 0);

    // Phase offset and enable gating
    duty_in = 5'd4; push2(4, 4, 0);
    run(40);
    en = 1'b0;
    run(10);
    check_eq("en_duty_hold", int'(duty_a), 4);
    check_eq("en_pwm_low", int'(pwm_a), 0);
    en = 1'b1;
    run(1);
    check_eq("en_restart", int'(pwm_a), 1);
    run(39);

    // Re-enter triangle, then async reset with no clock edge
    mode = 2'd0; push2(8, 9, 0);
    run(60);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_duty", int'(duty_a), 0);
    check_eq("arst_pwm", int'(pwm_a), 0);
    check_eq("arst_dir", int'(dir_b), 0);
    push2(4, 5, 0);
    run(1);
    rst_n = 1'b1;
    run(40);

`ifdef PWM_COMPL_EN
    mode = 2'd2; duty_in = 5'd8; push2(8, 8, 0);
    run(80);
    duty_in = 5'd1; push2(1, 1, 0);
    run(60);
`endif

    check_eq("sb_left_a", q_a.size(), 0);
    check_eq("sb_left_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
